// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller: tracks in-flight destinations and emits rs/rt bypass selects, load-use stalls and jump/branch flushes.
// Latency: bypass selects and stall are combinational from the decode word; a j/jr flush fires JUMP_DELAY unfrozen edges after decode.
// Backpressure: hold_ext freezes all state (outputs still evaluated); stall holds decode and feeds a bubble into EX.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   instruction          decode-stage instruction word
//   inst_valid           instruction holds a real instruction
//   hold_ext             external pipeline freeze
//   branch_taken         bltz resolved taken in EX this cycle
//   fwd_sel_a/fwd_sel_b  rs/rt source: 0 = register file, k = downstream stage k (1 = EX)
//   stall                hold PC/decode, bubble enters EX
//   flush                squash the decode-stage instruction
//   stall_cnt/flush_cnt  saturating counts of unfrozen stall/flush cycles
module hazard_forward_unit #(
    parameter int REG_ADDR_W     = 5,
    parameter int FWD_DEPTH      = 2,
    parameter int LOAD_FWD_STAGE = 2,
    parameter int JUMP_DELAY     = 1,
    parameter int CNT_W          = 16,
    localparam int SEL_W         = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             inst_valid,
    input  logic             hold_ext,
    input  logic             branch_taken,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BLTZ    = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // One scoreboard slot per downstream stage
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  load;
    } sb_entry_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] src_rs;
    logic [REG_ADDR_W-1:0] src_rt;
    logic [REG_ADDR_W-1:0] dst_rd;

    logic                  use_rs;
    logic                  use_rt;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_dst;
    logic                  dec_load;
    logic                  dec_jump;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];
    assign src_rs = REG_ADDR_W'(instruction[25:21]);
    assign src_rt = REG_ADDR_W'(instruction[20:16]);
    assign dst_rd = REG_ADDR_W'(instruction[15:11]);

    // shamt field plays no part in hazard detection
    logic unused_shamt;
    assign unused_shamt = ^instruction[10:6];

    always_comb begin
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        wr_en    = 1'b0;
        wr_dst   = '0;
        dec_load = 1'b0;
        dec_jump = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_SUBU, FN_NOR, FN_SLTU: begin
                        use_rs = 1'b1;
                        use_rt = 1'b1;
                        wr_en  = 1'b1;
                        wr_dst = dst_rd;
                    end
                    FN_JR: begin
                        use_rs   = 1'b1;
                        dec_jump = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                use_rs = 1'b1;
                wr_en  = 1'b1;
                wr_dst = src_rt;
            end
            OP_LW: begin
                use_rs   = 1'b1;
                wr_en    = 1'b1;
                wr_dst   = src_rt;
                dec_load = 1'b1;
            end
            OP_SW: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_BLTZ: use_rs = 1'b1;
            OP_J:    dec_jump = 1'b1;
            default: ;
        endcase
        // $0 is hard-wired, so a write to it never creates a dependency
        if (wr_dst == '0) begin
            wr_en = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: sb_q[1] is EX, sb_q[FWD_DEPTH] the oldest tracked stage
    // ------------------------------------------------------------------
    sb_entry_t [FWD_DEPTH:1] sb_q;
    sb_entry_t               entry_in;
    logic                    accept;

    logic [FWD_DEPTH:1]      hit_rs;
    logic [FWD_DEPTH:1]      hit_rt;
    logic                    load_hit;

    logic [JUMP_DELAY-1:0]   jmp_dly;
    logic                    jump_in;

    // Only an instruction that really leaves decode enters the pipe
    assign accept   = inst_valid & ~stall & ~flush;
    assign entry_in = {accept & wr_en, wr_dst, dec_load};
    assign jump_in  = accept & dec_jump;

    always_comb begin
        hit_rs = '0;
        hit_rt = '0;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            hit_rs[k] = sb_q[k].valid & use_rs & (sb_q[k].dest == src_rs);
            hit_rt[k] = sb_q[k].valid & use_rt & (sb_q[k].dest == src_rt);
        end
    end

    // Scan oldest to youngest so the youngest producer overrides older ones
    always_comb begin
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        load_hit  = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (hit_rs[k]) begin
                fwd_sel_a = SEL_W'(k);
            end
            if (hit_rt[k]) begin
                fwd_sel_b = SEL_W'(k);
            end
            // Load data is not ready before LOAD_FWD_STAGE; the stall drops
            // by itself once the load walks far enough down the pipe.
            if ((k < LOAD_FWD_STAGE) && sb_q[k].load && (hit_rs[k] | hit_rt[k])) begin
                load_hit = 1'b1;
            end
        end
    end

    // A flush squashes decode, so a load-use stall against it is moot
    assign flush = jmp_dly[JUMP_DELAY-1] | branch_taken;
    assign stall = load_hit & ~flush;

    if (FWD_DEPTH > 1) begin : g_sb_deep
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sb_q <= '0;
            end else if (!hold_ext) begin
                sb_q <= {sb_q[FWD_DEPTH-1:1], entry_in};
            end
        end
    end else begin : g_sb_single
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sb_q <= '0;
            end else if (!hold_ext) begin
                sb_q <= entry_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Jump delay line: bit i set means a jump left decode i+1 unfrozen edges ago
    // ------------------------------------------------------------------
    if (JUMP_DELAY > 1) begin : g_jmp_deep
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                jmp_dly <= '0;
            end else if (!hold_ext) begin
                jmp_dly <= {jmp_dly[JUMP_DELAY-2:0], jump_in};
            end
        end
    end else begin : g_jmp_single
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                jmp_dly <= '0;
            end else if (!hold_ext) begin
                jmp_dly <= jump_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters, frozen together with the pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!hold_ext) begin
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (default parameters and a
// deeper/slower variant with narrow counters) share one stimulus stream.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic        inst_valid = 1'b0;
    logic        hold_ext = 1'b0;
    logic        branch_taken = 1'b0;

    logic [1:0]  sel_a0, sel_b0, sel_a1, sel_b1;
    logic        stall0, flush0, stall1, flush1;
    logic [15:0] scnt0, fcnt0;
    logic [3:0]  scnt1, fcnt1;

    always #5 clk = ~clk;

    hazard_forward_unit u0 (
        .clk(clk), .rst(rst), .instruction(instruction), .inst_valid(inst_valid),
        .hold_ext(hold_ext), .branch_taken(branch_taken),
        .fwd_sel_a(sel_a0), .fwd_sel_b(sel_b0), .stall(stall0), .flush(flush0),
        .stall_cnt(scnt0), .flush_cnt(fcnt0)
    );

    hazard_forward_unit #(
        .FWD_DEPTH(3), .LOAD_FWD_STAGE(3), .JUMP_DELAY(2), .CNT_W(4)
    ) u1 (
        .clk(clk), .rst(rst), .instruction(instruction), .inst_valid(inst_valid),
        .hold_ext(hold_ext), .branch_taken(branch_taken),
        .fwd_sel_a(sel_a1), .fwd_sel_b(sel_b1), .stall(stall1), .flush(flush1),
        .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] rtype(input int fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit urs, urt, wr, ld, jmp;
        int rs, rt, wd;
    } dec_t;

    typedef struct { int u; int t; int dest; bit ld; } rec_t;   // in-flight writer, issued at edge t
    typedef struct { int u; int t; } jrec_t;                    // jump left decode at edge t

    rec_t  recs[$];
    jrec_t jumps[$];
    int    now[2];
    int    mscnt[2];
    int    mfcnt[2];

    function automatic int fd(input int u);   return (u == 0) ? 2 : 3;  endfunction
    function automatic int lfs(input int u);  return (u == 0) ? 2 : 3;  endfunction
    function automatic int jd(input int u);   return (u == 0) ? 1 : 2;  endfunction
    function automatic int cmax(input int u); return (u == 0) ? 65535 : 15; endfunction

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        int op, fn;
        d = '{default: 0};
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        d.rs = int'(w[25:21]);
        d.rt = int'(w[20:16]);
        if (op == 0 && (fn == 'h23 || fn == 'h27 || fn == 'h2B)) begin
            d.urs = 1; d.urt = 1; d.wr = 1; d.wd = int'(w[15:11]);
        end else if (op == 0 && fn == 'h08) begin
            d.urs = 1; d.jmp = 1;
        end else if (op == 'h08 || op == 'h23) begin
            d.urs = 1; d.wr = 1; d.wd = d.rt; d.ld = (op == 'h23);
        end else if (op == 'h2B) begin
            d.urs = 1; d.urt = 1;
        end else if (op == 'h01) begin
            d.urs = 1;
        end else if (op == 'h02) begin
            d.jmp = 1;
        end
        if (d.wd == 0) d.wr = 0;
        return d;
    endfunction

    task automatic model_reset();
        recs.delete();
        jumps.delete();
        for (int u = 0; u < 2; u++) begin
            now[u] = 0; mscnt[u] = 0; mfcnt[u] = 0;
        end
    endtask

    task automatic model_eval(input int u, input dec_t d, input bit bt,
                              output int ea, output int eb, output bit est, output bit efl);
        int ba, bb, k;
        bit ma, mb;
        ba = 99; bb = 99; est = 0; efl = bt;
        foreach (jumps[i]) begin
            if (jumps[i].u == u && now[u] - jumps[i].t == jd(u)) efl = 1;
        end
        foreach (recs[i]) begin
            if (recs[i].u == u) begin
                k = now[u] - recs[i].t;
                if (k >= 1 && k <= fd(u)) begin
                    ma = d.urs && (recs[i].dest == d.rs);
                    mb = d.urt && (recs[i].dest == d.rt);
                    if (ma && k < ba) ba = k;
                    if (mb && k < bb) bb = k;
                    if (recs[i].ld && k < lfs(u) && (ma || mb)) est = 1;
                end
            end
        end
        ea = (ba == 99) ? 0 : ba;
        eb = (bb == 99) ? 0 : bb;
        if (efl) est = 0;
    endtask

    task automatic model_step(input int u, input dec_t d, input bit vld, input bit hold,
                              input bit est, input bit efl);
        bit acc;
        if (hold) return;
        if (est && mscnt[u] < cmax(u)) mscnt[u]++;
        if (efl && mfcnt[u] < cmax(u)) mfcnt[u]++;
        acc = vld && !est && !efl;
        if (acc && d.wr)  recs.push_back('{u, now[u], d.wd, d.ld});
        if (acc && d.jmp) jumps.push_back('{u, now[u]});
        now[u]++;
        for (int i = recs.size() - 1; i >= 0; i--)
            if (recs[i].u == u && now[u] - recs[i].t > fd(u)) recs.delete(i);
        for (int i = jumps.size() - 1; i >= 0; i--)
            if (jumps[i].u == u && now[u] - jumps[i].t > jd(u)) jumps.delete(i);
    endtask

    task automatic get_out(input int u, output int a, output int b, output int st,
                           output int fl, output int sc, output int fc);
        if (u == 0) begin
            a = int'(sel_a0); b = int'(sel_b0); st = int'(stall0); fl = int'(flush0);
            sc = int'(scnt0); fc = int'(fcnt0);
        end else begin
            a = int'(sel_a1); b = int'(sel_b1); st = int'(stall1); fl = int'(flush1);
            sc = int'(scnt1); fc = int'(fcnt1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; instruction = '0; inst_valid = 1'b0; hold_ext = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] ins;
        bit bt;
        int ea, eb;
        bit est, efl, csel;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] ins, input bit bt, input int ea, input int eb,
                                input bit est, input bit efl, input bit csel);
        vec_t v;
        v.ins = ins; v.bt = bt; v.ea = ea; v.eb = eb; v.est = est; v.efl = efl; v.csel = csel;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [31:0] J, LW5, ADDI6;
        dec_t d;
        int ea, eb, a, b, st, fl, sc, fc, kind;
        bit est, efl;

        J     = itype('h02, 0, 0, 0);
        LW5   = itype('h23, 1, 5, 0);
        ADDI6 = itype('h08, 5, 6, 4);

        //             instruction                bt  a  b  st fl csel
        tbl.push_back(mk(rtype('h23, 3, 1, 2),    0, 0, 0, 0, 0, 1)); // subu $3,$1,$2
        tbl.push_back(mk(rtype('h27, 4, 3, 3),    0, 1, 1, 0, 0, 1)); // nor $4,$3,$3
        tbl.push_back(mk(rtype('h23, 3, 1, 2),    0, 0, 0, 0, 0, 1)); // subu $3,$1,$2
        tbl.push_back(mk(itype('h08, 1, 9, 0),    0, 0, 0, 0, 0, 1)); // addi $9,$1,0
        tbl.push_back(mk(rtype('h27, 4, 3, 3),    0, 2, 2, 0, 0, 1)); // nor $4,$3,$3
        tbl.push_back(mk(itype('h08, 1, 0, 1),    0, 0, 0, 0, 0, 1)); // addi $0,$1,1
        tbl.push_back(mk(rtype('h23, 2, 0, 0),    0, 0, 0, 0, 0, 1)); // subu $2,$0,$0
        tbl.push_back(mk(itype('h08, 1, 7, 1),    0, 0, 0, 0, 0, 1)); // addi $7,$1,1
        tbl.push_back(mk(rtype('h23, 7, 2, 3),    0, 2, 0, 0, 0, 1)); // subu $7,$2,$3
        tbl.push_back(mk(rtype('h2B, 8, 7, 7),    0, 1, 1, 0, 0, 1)); // sltu $8,$7,$7
        tbl.push_back(mk(LW5,                     0, 0, 0, 0, 0, 1)); // lw $5,0($1)
        tbl.push_back(mk(ADDI6,                   0, 0, 0, 1, 0, 0)); // addi $6,$5,4 stalls
        tbl.push_back(mk(ADDI6,                   0, 2, 0, 0, 0, 1)); // re-issued, load at stage 2
        tbl.push_back(mk(rtype('h23, 10, 6, 5),   0, 1, 0, 0, 0, 1)); // subu $10,$6,$5
        tbl.push_back(mk(J,                       0, 0, 0, 0, 0, 1)); // j
        tbl.push_back(mk(itype('h08, 10, 11, 0),  0, 2, 0, 0, 1, 1)); // squashed
        tbl.push_back(mk(itype('h08, 11, 12, 0),  0, 0, 0, 0, 0, 1)); // $11 never entered
        tbl.push_back(mk(itype('h23, 1, 13, 0),   0, 0, 0, 0, 0, 1)); // lw $13
        tbl.push_back(mk(J,                       1, 0, 0, 0, 1, 1)); // j during flush: ignored
        tbl.push_back(mk(itype('h08, 13, 14, 0),  0, 2, 0, 0, 0, 1)); // no jump flush follows
        tbl.push_back(mk(itype('h23, 1, 15, 0),   0, 0, 0, 0, 0, 1)); // lw $15
        tbl.push_back(mk(itype('h08, 15, 16, 0),  1, 1, 0, 0, 1, 1)); // flush beats stall
        tbl.push_back(mk(itype('h08, 15, 16, 0),  0, 2, 0, 0, 0, 1)); // addi $16,$15,0

        // ---- reset state ----
        do_reset();
        #1;
        chk("rst_stall0", int'(stall0), 0);
        chk("rst_flush0", int'(flush0), 0);
        chk("rst_sel_a0", int'(sel_a0), 0);
        chk("rst_sel_b0", int'(sel_b0), 0);
        chk("rst_scnt1", int'(scnt1), 0);
        chk("rst_fcnt1", int'(fcnt1), 0);

        // ---- table-driven forwarding / stall / flush ----
        for (int i = 0; i < tbl.size(); i++) begin
            instruction = tbl[i].ins; inst_valid = 1'b1; hold_ext = 1'b0; branch_taken = tbl[i].bt;
            #1;
            chk($sformatf("tbl%0d_stall", i), int'(stall0), int'(tbl[i].est));
            chk($sformatf("tbl%0d_flush", i), int'(flush0), int'(tbl[i].efl));
            if (tbl[i].csel) begin
                chk($sformatf("tbl%0d_sel_a", i), int'(sel_a0), tbl[i].ea);
                chk($sformatf("tbl%0d_sel_b", i), int'(sel_b0), tbl[i].eb);
            end
            @(negedge clk);
        end
        chk("tbl_stall_cnt", int'(scnt0), 1);
        chk("tbl_flush_cnt", int'(fcnt0), 3);

        // ---- jump held in decode by hold_ext, then flush frozen by hold_ext ----
        do_reset();
        instruction = J; inst_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            hold_ext = (c < 3);
            #1;
            chk($sformatf("jh%0d_flush0", c), int'(flush0), 0);
            chk($sformatf("jh%0d_flush1", c), int'(flush1), 0);
            @(negedge clk);
        end
        instruction = '0;
        for (int c = 4; c < 9; c++) begin
            hold_ext = (c == 4 || c == 5);
            #1;
            chk($sformatf("jh%0d_flush0", c), int'(flush0), (c >= 4 && c <= 6) ? 1 : 0);
            chk($sformatf("jh%0d_flush1", c), int'(flush1), (c == 7) ? 1 : 0);
            @(negedge clk);
        end
        chk("jh_fcnt0", int'(fcnt0), 1);
        chk("jh_fcnt1", int'(fcnt1), 1);

        // ---- load-use: one stall cycle by default, two with LOAD_FWD_STAGE=3 ----
        do_reset();
        instruction = LW5; inst_valid = 1'b1;
        #1;
        chk("lu0_stall0", int'(stall0), 0);
        @(negedge clk);
        instruction = ADDI6;
        #1;
        chk("lu1_stall0", int'(stall0), 1);
        chk("lu1_stall1", int'(stall1), 1);
        @(negedge clk);
        #1;
        chk("lu2_stall0", int'(stall0), 0);
        chk("lu2_sel_a0", int'(sel_a0), 2);
        chk("lu2_stall1", int'(stall1), 1);
        @(negedge clk);
        #1;
        chk("lu3_stall1", int'(stall1), 0);
        chk("lu3_sel_a1", int'(sel_a1), 3);
        chk("lu3_scnt0", int'(scnt0), 1);
        chk("lu3_scnt1", int'(scnt1), 2);
        @(negedge clk);

        // ---- async reset in the middle of a stall ----
        instruction = LW5;
        @(negedge clk);
        instruction = ADDI6;
        #1;
        chk("rs_pre_stall0", int'(stall0), 1);
        #1;
        rst = 1'b1; branch_taken = 1'b1;
        #1;
        chk("rs_stall0", int'(stall0), 0);
        chk("rs_stall1", int'(stall1), 0);
        chk("rs_sel_a0", int'(sel_a0), 0);
        chk("rs_flush_bt", int'(flush0), 1);
        chk("rs_scnt0", int'(scnt0), 0);
        chk("rs_scnt1", int'(scnt1), 0);
        branch_taken = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rs_post_stall0", int'(stall0), 0);
        chk("rs_post_sel_a0", int'(sel_a0), 0);
        @(negedge clk);
        #1;
        chk("rs_post_scnt0", int'(scnt0), 0);
        chk("rs_post_fcnt0", int'(fcnt0), 0);

        // ---- randomized run against the reference model ----
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            inst_valid   = ($urandom_range(0, 9) != 0);
            hold_ext     = ($urandom_range(0, 6) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            kind = $urandom_range(0, 10);
            case (kind)
                0:  instruction = rtype('h23, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                1:  instruction = rtype('h27, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                2:  instruction = rtype('h2B, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                3:  instruction = rtype('h08, 0, $urandom_range(0, 7), 0);
                4:  instruction = itype('h08, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
                5:  instruction = itype('h23, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
                6:  instruction = itype('h2B, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
                7:  instruction = itype('h01, $urandom_range(0, 7), 0, $urandom_range(0, 65535));
                8:  instruction = itype('h02, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
                9:  instruction = itype('h0F, $urandom_range(0, 7), $urandom_range(0, 7), 0);
                default: instruction = rtype('h21, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            endcase
            if (!inst_valid) instruction = '0;
            #1;
            d = decode(instruction);
            for (int u = 0; u < 2; u++) begin
                model_eval(u, d, branch_taken, ea, eb, est, efl);
                get_out(u, a, b, st, fl, sc, fc);
                chk($sformatf("rnd%0d_u%0d_stall", cyc, u), st, int'(est));
                chk($sformatf("rnd%0d_u%0d_flush", cyc, u), fl, int'(efl));
                if (!est) begin
                    chk($sformatf("rnd%0d_u%0d_sel_a", cyc, u), a, ea);
                    chk($sformatf("rnd%0d_u%0d_sel_b", cyc, u), b, eb);
                end
                chk($sformatf("rnd%0d_u%0d_scnt", cyc, u), sc, mscnt[u]);
                chk($sformatf("rnd%0d_u%0d_fcnt", cyc, u), fc, mfcnt[u]);
                model_step(u, d, inst_valid, hold_ext, est, efl);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
